// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin trigger/echo timer sharing one ranging engine among several ultrasonic sensors
module ultrasonic_scheduler #(
  parameter int NUM_SENSORS = 4,
  parameter int ID_W = 2,
  parameter int TRIG_CYCLES = 500,
  parameter int CM_CYCLES = 2900,
  parameter int MAX_CM = 400,
  parameter int DIST_W = 9,
  parameter int RISE_TIMEOUT = 100000,
  parameter int HOLDOFF_CYCLES = 3000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   result_valid,
  output logic [ID_W-1:0]        result_id,
  output logic [DIST_W-1:0]      result_cm,
  output logic                   result_timeout,
  output logic                   sweep_done,
  output logic                   busy
);
  localparam int MAXC = TRIG_CYCLES > RISE_TIMEOUT
    ? (TRIG_CYCLES > HOLDOFF_CYCLES ? TRIG_CYCLES : HOLDOFF_CYCLES)
    : (RISE_TIMEOUT > HOLDOFF_CYCLES ? RISE_TIMEOUT : HOLDOFF_CYCLES);
  localparam int TW = $clog2(MAXC);
  localparam int SW = $clog2(CM_CYCLES);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [SW-1:0] sub;
  logic [DIST_W-1:0] cm;
  logic [ID_W-1:0] sel, sel_next;
  logic [NUM_SENSORS-1:0] echo_m, echo_q;
  logic echo_s, last_id;
  assign echo_s = echo_q[sel];
  assign sel_next = (sel == ID_W'(NUM_SENSORS - 1)) ? '0 : sel + 1'b1;
  assign last_id = sel == ID_W'(NUM_SENSORS - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      sub <= '0;
      cm <= '0;
      sel <= '0;
      echo_m <= '0;
      echo_q <= '0;
      trig <= '0;
      result_valid <= 1'b0;
      result_id <= '0;
      result_cm <= '0;
      result_timeout <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_q <= echo_m;
      result_valid <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state <= TRIG;
          timer <= '0;
          trig <= NUM_SENSORS'(1) << sel;
        end
        TRIG: if (timer == TW'(TRIG_CYCLES - 1)) begin
          trig <= '0;
          state <= WAIT_RISE;
          timer <= '0;
        end else timer <= timer + 1'b1;
        WAIT_RISE: if (echo_s) begin
          state <= MEASURE;
          sub <= '0;
          cm <= '0;
        end else if (timer == TW'(RISE_TIMEOUT - 1)) begin
          {result_valid, result_id, result_cm, result_timeout, sweep_done} <= {1'b1, sel, DIST_W'(MAX_CM), 1'b1, last_id};
          state <= HOLDOFF;
          timer <= '0;
        end else timer <= timer + 1'b1;
        MEASURE: if (!echo_s) begin
          {result_valid, result_id, result_cm, result_timeout, sweep_done} <= {1'b1, sel, cm, 1'b0, last_id};
          state <= HOLDOFF;
          timer <= '0;
        end else if (sub == SW'(CM_CYCLES - 1)) begin
          sub <= '0;
          // reaching the range limit ends the shot without waiting for the echo to fall
          if (cm == DIST_W'(MAX_CM - 1)) begin
            {result_valid, result_id, result_cm, result_timeout, sweep_done} <= {1'b1, sel, DIST_W'(MAX_CM), 1'b1, last_id};
            state <= HOLDOFF;
            timer <= '0;
          end else cm <= cm + 1'b1;
        end else sub <= sub + 1'b1;
        HOLDOFF: if (timer == TW'(HOLDOFF_CYCLES - 1)) begin
          sel <= sel_next;
          timer <= '0;
          state <= enable ? TRIG : IDLE;
          trig <= enable ? NUM_SENSORS'(1) << sel_next : '0;
        end else timer <= timer + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
- Round-robin controller that shares one measurement engine among NUM_SENSORS HC-SR04-style ultrasonic sensors.
- Fires each sensor's trigger, times its echo pulse, and converts the echo width to centimetres.
- Flags missing or over-range echoes and enforces a holdoff between shots so echoes from different sensors cannot cross-talk.
- Sits between the GPIO trig/echo pins and the display/BCD path; replaces free-running per-sensor timers.

Parameters:
- NUM_SENSORS, 4, number of sensors served; 2..16.
- ID_W, 2, width of sensor index; must satisfy 2^ID_W >= NUM_SENSORS.
- TRIG_CYCLES, 500, trigger pulse length in clocks (10 us at 50 MHz).
- CM_CYCLES, 2900, echo clocks per centimetre (58 us at 50 MHz).
- MAX_CM, 400, range limit in centimetres; echo reaching this width is over-range.
- DIST_W, 9, result width; must hold MAX_CM.
- RISE_TIMEOUT, 100000, maximum clocks from trigger end to echo rise.
- HOLDOFF_CYCLES, 3000000, idle clocks after each result (60 ms).

Ports:
- clock  input  1  system clock (50 MHz)
- reset  input  1  asynchronous, active-high reset
- enable  input  1  run continuous sweeps while high
- echo  input  NUM_SENSORS  raw echo pins, asynchronous to clock
- trig  output  NUM_SENSORS  trigger pins, registered
- result_valid  output  1  one-cycle pulse; result_* fields valid
- result_id  output  ID_W  sensor index of the result
- result_cm  output  DIST_W  distance in cm, floor(echo_clocks / CM_CYCLES)
- result_timeout  output  1  1 = no echo or over-range
- sweep_done  output  1  one-cycle pulse, coincident with result_valid for sensor NUM_SENSORS-1
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous, active-high:
  - all outputs 0, sel = 0, state = IDLE, all counters 0, synchroniser flops 0.
  - Asserting reset mid-measurement drops trig immediately.
- Echo synchronisation: each echo bit passes through 2 flops. echo_s is echo[sel] after this 2-cycle latency; all decisions use echo_s.
- State machine, one timer counter shared across states:
  - IDLE: if enable is high, go to TRIG with timer = 0. sel is not changed.
  - TRIG: trig[sel] = 1 and all other trig bits 0, for exactly TRIG_CYCLES consecutive clocks. Then trig = 0 and go to WAIT_RISE with timer = 0.
  - WAIT_RISE:
    - echo_s = 1: go to MEASURE, clear sub and cm.
    - else, timer reaches RISE_TIMEOUT-1: emit result with cm = MAX_CM, timeout = 1, go to HOLDOFF.
  - MEASURE, for each cycle with echo_s = 1:
    - sub increments.
    - When sub == CM_CYCLES-1, sub wraps to 0 and cm increments.
    - If cm would reach MAX_CM: emit result with cm = MAX_CM, timeout = 1, go to HOLDOFF without waiting for the echo to fall.
  - MEASURE, echo_s = 0: emit result with current cm, timeout = 0, go to HOLDOFF.
  - HOLDOFF:
    - Count HOLDOFF_CYCLES clocks.
    - Then sel advances: sel+1, wrapping to 0 after NUM_SENSORS-1.
    - Next state is TRIG if enable is high, else IDLE.
- Emit result: in the cycle after the decision, result_valid = 1 for exactly one clock with id/cm/timeout.
  - result_id/cm/timeout hold their values until the next result.
  - sweep_done pulses alongside when id == NUM_SENSORS-1.
- enable is sampled only in IDLE and at HOLDOFF exit. Dropping it mid-shot completes the current shot, including its holdoff, then stops in IDLE.
- Echo already high at trigger end (stuck pin) is measured as a pulse starting at WAIT_RISE entry; a stuck-high pin yields an over-range timeout.
- Echo glitches on non-selected sensors are ignored.
- Arithmetic: cm saturates at MAX_CM and never wraps; timer width = clog2 of the largest cycle parameter.

Test Plan:
Bench parameters: NUM_SENSORS=3, TRIG_CYCLES=4, CM_CYCLES=10, MAX_CM=20, RISE_TIMEOUT=50, HOLDOFF_CYCLES=8.
- Reset, then enable=1 -> trig[0] high for exactly 4 clocks, trig[2:1] stay 0, busy=1.
- Sensor 0 echo high 125 clocks, 20 cycles after trigger -> result_valid once: id=0, cm=12, timeout=0.
- Sensor 1 echo never rises -> 50 clocks after trigger falls, result id=1, cm=20, timeout=1.
- Sensor 2 echo held high 500 clocks -> result id=2, cm=20, timeout=1 after 200 echo clocks; sweep_done pulses; the next trigger is trig[0].
- enable dropped during sensor 1 MEASURE -> result for id=1 is still emitted; after 8 holdoff clocks state is IDLE, busy=0, no further trig; re-enable -> trig[2] fires next.
- reset asserted mid-TRIG -> trig=0 asynchronously, no result_valid, restart fires trig[0].
